// File: rtl/fpu_result_buffer.sv
// Result FIFO behind the FPU output port: buffers {result, status, tag},
// keeps sticky exception flags and counts results handed to the consumer.
module fpu_result_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int TAG_W = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [WIDTH-1:0]           fpu_result_i,
  input  logic [4:0]                 fpu_status_i,
  input  logic [TAG_W-1:0]           fpu_tag_i,
  input  logic                       fpu_valid_i,
  output logic                       fpu_ready_o,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           res_data_o,
  output logic [4:0]                 res_status_o,
  output logic [TAG_W-1:0]           res_tag_o,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [4:0]                 fflags_o,
  input  logic                       fflags_clr_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [15:0]                pop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ENT_W = WIDTH + 5 + TAG_W;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       fflags_q, fflags_d;
  logic [15:0]      pop_cnt_q, pop_cnt_d;
  logic             push, pop, push_eff;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Both ports transfer on an edge where valid && ready; ready depends only on
  // registered occupancy, so consumer stalls never reach fpu_ready_o in the same cycle.
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign fpu_ready_o = !full_o;
  assign res_valid_o = !empty_o;
  assign push        = fpu_valid_i && fpu_ready_o;
  assign pop         = res_valid_o && res_ready_i;
  assign push_eff    = push && !flush_i;

  assign {res_data_o, res_status_o, res_tag_o} = mem_q[rptr_q];
  assign count_o   = count_q;
  assign fflags_o  = fflags_q;
  assign pop_cnt_o = pop_cnt_q;

  always_comb begin
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    pop_cnt_d = pop_cnt_q;
    fflags_d  = fflags_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = {fpu_result_i, fpu_status_i, fpu_tag_i};
        wptr_d        = ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_d    = ptr_inc(rptr_q);
        pop_cnt_d = pop_cnt_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    // A status pushed in the clearing cycle survives the clear.
    if (fflags_clr_i)  fflags_d = push_eff ? fpu_status_i : 5'd0;
    else if (push_eff) fflags_d = fflags_q | fpu_status_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      fflags_q  <= '0;
      pop_cnt_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      fflags_q  <= fflags_d;
      pop_cnt_q <= pop_cnt_d;
    end
  end

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Directed bench for fpu_result_buffer: a DEPTH=4 instance with a full reference
// model and a DEPTH=3 instance for pointer wrap under continuous streaming.
module tb_fpu_result_buffer;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH = 4 instance
  logic [15:0] fpu_result;
  logic [4:0]  fpu_status;
  logic [0:0]  fpu_tag;
  logic        fpu_valid, fpu_ready, flush;
  logic [15:0] res_data;
  logic [4:0]  res_status;
  logic [0:0]  res_tag;
  logic        res_valid, res_ready;
  logic [4:0]  fflags;
  logic        fflags_clr;
  logic [2:0]  count;
  logic        full, empty;
  logic [15:0] pop_cnt;

  fpu_result_buffer #(.WIDTH(16), .DEPTH(4), .TAG_W(1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag),
    .fpu_valid_i(fpu_valid), .fpu_ready_o(fpu_ready), .flush_i(flush),
    .res_data_o(res_data), .res_status_o(res_status), .res_tag_o(res_tag),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .fflags_o(fflags), .fflags_clr_i(fflags_clr),
    .count_o(count), .full_o(full), .empty_o(empty), .pop_cnt_o(pop_cnt)
  );

  // DEPTH = 3 instance
  logic [15:0] fpu_result3;
  logic        fpu_valid3, fpu_ready3;
  logic [15:0] res_data3;
  logic [4:0]  res_status3;
  logic [0:0]  res_tag3;
  logic        res_valid3, res_ready3;
  logic [4:0]  fflags3;
  logic [1:0]  count3;
  logic        full3, empty3;
  logic [15:0] pop_cnt3;

  fpu_result_buffer #(.WIDTH(16), .DEPTH(3), .TAG_W(1)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .fpu_result_i(fpu_result3), .fpu_status_i(5'd0), .fpu_tag_i(1'b0),
    .fpu_valid_i(fpu_valid3), .fpu_ready_o(fpu_ready3), .flush_i(1'b0),
    .res_data_o(res_data3), .res_status_o(res_status3), .res_tag_o(res_tag3),
    .res_valid_o(res_valid3), .res_ready_i(res_ready3),
    .fflags_o(fflags3), .fflags_clr_i(1'b0),
    .count_o(count3), .full_o(full3), .empty_o(empty3), .pop_cnt_o(pop_cnt3)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard and reference model, DEPTH = 4 instance
  logic [21:0] exp_q[$];
  logic [4:0]  m_flags  = '0;
  logic [15:0] m_popcnt = '0;
  bit          m_push, m_pop;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 32'(count), exp_q.size());
      chk("empty", 32'(empty), exp_q.size() == 0);
      chk("full", 32'(full), exp_q.size() == 4);
      chk("res_valid", 32'(res_valid), exp_q.size() != 0);
      chk("fpu_ready", 32'(fpu_ready), exp_q.size() < 4);
      chk("fflags", 32'(fflags), 32'(m_flags));
      chk("pop_cnt", 32'(pop_cnt), 32'(m_popcnt));
      if (exp_q.size() != 0) chk("head", {10'd0, res_data, res_status, res_tag}, 32'(exp_q[0]));
    end
    if (!rst_n) begin
      exp_q.delete();
      m_flags  = '0;
      m_popcnt = '0;
    end else if (flush) begin
      exp_q.delete();
      if (fflags_clr) m_flags = '0;
    end else begin
      m_push = fpu_valid && (exp_q.size() < 4);
      m_pop  = (exp_q.size() != 0) && res_ready;
      if (m_pop) begin
        void'(exp_q.pop_front());
        m_popcnt++;
      end
      if (m_push) exp_q.push_back({fpu_result, fpu_status, fpu_tag});
      if (fflags_clr) m_flags = m_push ? fpu_status : 5'd0;
      else if (m_push) m_flags = m_flags | fpu_status;
    end
  end

  // scoreboard, DEPTH = 3 instance
  logic [15:0] exp3_q[$];
  bit          m3_push, m3_pop;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("count3", 32'(count3), exp3_q.size());
      if (res_valid3 && res_ready3) begin
        if (exp3_q.size() == 0) chk("pop3_unexpected", 32'(res_valid3), 0);
        else chk("pop3_data", 32'(res_data3), 32'(exp3_q[0]));
      end
    end
    if (!rst_n) exp3_q.delete();
    else begin
      m3_push = fpu_valid3 && (exp3_q.size() < 3);
      m3_pop  = (exp3_q.size() != 0) && res_ready3;
      if (m3_pop) void'(exp3_q.pop_front());
      if (m3_push) exp3_q.push_back(fpu_result3);
    end
  end

  // driver tasks
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [4:0] s, input logic t);
    bit acc;
    int k;
    fpu_result = d;
    fpu_status = s;
    fpu_tag    = t;
    fpu_valid  = 1'b1;
    acc = 1'b0;
    k   = 0;
    while (!acc && k < 50) begin
      @(negedge clk);
      acc = fpu_ready;
      @(posedge clk);
      #1;
      k++;
    end
    chk("send_accept", 32'(acc), 1);
  endtask

  task automatic chk_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_data", 32'(res_data), 0);
    chk("rst_status", 32'(res_status), 0);
    chk("rst_tag", 32'(res_tag), 0);
    chk("rst_fflags", 32'(fflags), 0);
    chk("rst_pop_cnt", 32'(pop_cnt), 0);
    chk("rst_ready", 32'(fpu_ready), 1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; fflags_clr = 1'b0;
    fpu_result = '0; fpu_status = '0; fpu_tag = '0; fpu_valid = 1'b0; res_ready = 1'b0;
    fpu_result3 = '0; fpu_valid3 = 1'b0; res_ready3 = 1'b0;
    step(2);
    rst_n = 1'b1;
    mon_en = 1'b1;
    chk_reset();

    // single pass-through
    res_ready = 1'b1;
    send(16'h3C00, 5'b00001, 1'b1);
    fpu_valid = 1'b0;
    chk("pt_valid", 32'(res_valid), 1);
    chk("pt_data", 32'(res_data), 32'h3C00);
    chk("pt_tag", 32'(res_tag), 1);
    chk("pt_fflags", 32'(fflags), 32'b00001);
    step(1);
    chk("pt_pop_cnt", 32'(pop_cnt), 1);
    chk("pt_empty", 32'(empty), 1);

    // fill and back-pressure
    res_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send(16'(k), 5'd0, 1'b0);
    chk("fill_full", 32'(full), 1);
    chk("fill_ready", 32'(fpu_ready), 0);
    fpu_result = 16'h0005;
    step(2);
    chk("fill_hold_count", 32'(count), 4);
    chk("fill_hold_ready", 32'(fpu_ready), 0);
    res_ready = 1'b1;
    step(1);
    chk("fill_ready_rise", 32'(fpu_ready), 1);
    chk("fill_count3", 32'(count), 3);
    step(1);
    fpu_valid = 1'b0;
    chk("fill_5th_in", 32'(count), 3);
    step(3);
    chk("fill_drained", 32'(empty), 1);
    chk("fill_pop_cnt", 32'(pop_cnt), 6);

    // wrap-around, DEPTH = 3, simultaneous push and pop
    res_ready3 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fpu_result3 = 16'h0100 + 16'(i);
      fpu_valid3  = 1'b1;
      step(1);
      chk("wrap_count", 32'(count3), 1);
    end
    fpu_valid3 = 1'b0;
    step(1);
    chk("wrap_empty", 32'(count3), 0);
    chk("wrap_pop_cnt", 32'(pop_cnt3), 10);

    // flush with pending entries
    res_ready = 1'b0;
    send(16'h00A1, 5'b01000, 1'b0);
    send(16'h00A2, 5'b00000, 1'b1);
    send(16'h00A3, 5'b00000, 1'b0);
    fpu_valid = 1'b0;
    chk("fl_count_pre", 32'(count), 3);
    chk("fl_fflags_pre", 32'(fflags), 32'b01001);
    flush = 1'b1; res_ready = 1'b1;
    fpu_valid = 1'b1; fpu_result = 16'hDEAD; fpu_status = 5'b10000;
    step(1);
    flush = 1'b0; fpu_valid = 1'b0;
    chk("fl_count", 32'(count), 0);
    chk("fl_valid", 32'(res_valid), 0);
    chk("fl_fflags", 32'(fflags), 32'b01001);
    chk("fl_pop_cnt", 32'(pop_cnt), 6);
    step(1);
    chk("fl_no_dead", 32'(res_valid), 0);

    // fflags clear priority
    fflags_clr = 1'b1;
    step(1);
    fflags_clr = 1'b0;
    chk("clr_alone0", 32'(fflags), 0);
    send(16'h00B1, 5'b10000, 1'b0);
    fpu_valid = 1'b0;
    chk("clr_setup", 32'(fflags), 32'b10000);
    fflags_clr = 1'b1;
    send(16'h00B2, 5'b00100, 1'b1);
    fflags_clr = 1'b0;
    fpu_valid = 1'b0;
    chk("clr_push", 32'(fflags), 32'b00100);
    fflags_clr = 1'b1;
    step(1);
    fflags_clr = 1'b0;
    chk("clr_alone", 32'(fflags), 0);
    step(2);
    chk("clr_pop_cnt", 32'(pop_cnt), 8);

    // reset mid-operation
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 7; i++)
      send(16'h0C00 + 16'(i), (i == 0) ? 5'b00001 : (i == 1) ? 5'b00010 : 5'b00000, 1'(i));
    fpu_valid = 1'b0;
    step(2);
    chk("mid_pop_cnt", 32'(pop_cnt), 7);
    chk("mid_fflags", 32'(fflags), 32'b00011);
    res_ready = 1'b0;
    send(16'h0C11, 5'b00000, 1'b1);
    send(16'h0C12, 5'b00000, 1'b0);
    fpu_valid = 1'b0;
    chk("mid_count", 32'(count), 2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk_reset();
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
